monitor_contador: RTL

MONITOR_CONTADOR -- requirements
Module: monitor_contador

---
 rtl/monitor_contador.sv | 118 +++++++++++
 1 files changed

// File: rtl/monitor_contador.sv
// monitor_contador: passive lockstep checker comparing a reference 4-bit counter against its netlist.
// After a warmup window it flags, counts and captures the first divergence between the two.
module monitor_contador #(
    parameter int unsigned WARMUP  = 2,
    parameter int unsigned STAMP_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [3:0]         Q_a,
    input  logic               rco_a,
    input  logic               load_a,
    input  logic [3:0]         Q_b,
    input  logic               rco_b,
    input  logic               load_b,
    output logic [1:0]         state,
    output logic               mismatch,
    output logic               error,
    output logic [7:0]         mismatch_count,
    output logic [STAMP_W-1:0] first_cycle,
    output logic [3:0]         first_Q_a,
    output logic [3:0]         first_Q_b
);

    // state | meaning
    // IDLE  | enable low, nothing compared
    // WARM  | enabled, letting both counters settle for WARMUP cycles
    // CHECK | enabled, every sample compared
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WARM  = 2'b01,
        CHECK = 2'b10
    } state_t;

    localparam logic [4:0] WARMUP_L = 5'(WARMUP);

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_warm_cnt;
    logic [3:0]         w_next_warm_cnt;
    logic [STAMP_W-1:0] r_cyc;
    logic               r_mismatch;
    logic               r_error;
    logic [7:0]         r_mismatch_count;
    logic [STAMP_W-1:0] r_first_cycle;
    logic [3:0]         r_first_Q_a;
    logic [3:0]         r_first_Q_b;
    logic               w_warm_done;
    logic               w_diff;
    logic               w_mis;

    // Widened so the compare stays valid for WARMUP up to 15 without wrap.
    assign w_warm_done = (({1'b0, r_warm_cnt}) + 5'd1) == WARMUP_L;

    always_comb begin
        w_next_state    = r_state;
        w_next_warm_cnt = 4'd0;
        if (!enable) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_next_state = (WARMUP == 0) ? CHECK : WARM;
                WARM: begin
                    if (w_warm_done) begin
                        w_next_state = CHECK;
                    end else begin
                        w_next_warm_cnt = r_warm_cnt + 4'd1;
                    end
                end
                CHECK:   w_next_state = CHECK;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Case-inequality so an X or Z on either side is treated as a divergence.
    assign w_diff = (Q_a !== Q_b) || (rco_a !== rco_b) || (load_a !== load_b);
    assign w_mis  = (r_state == CHECK) && enable && w_diff;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_warm_cnt       <= 4'd0;
            r_cyc            <= '0;
            r_mismatch       <= 1'b0;
            r_error          <= 1'b0;
            r_mismatch_count <= 8'd0;
            r_first_cycle    <= '0;
            r_first_Q_a      <= 4'd0;
            r_first_Q_b      <= 4'd0;
        end else begin
            r_state    <= w_next_state;
            r_warm_cnt <= w_next_warm_cnt;
            r_cyc      <= r_cyc + STAMP_W'(1);
            r_mismatch <= w_mis;
            if (w_mis) begin
                r_error <= 1'b1;
                if (r_mismatch_count != 8'hFF) begin
                    r_mismatch_count <= r_mismatch_count + 8'd1;
                end
                if (!r_error) begin
                    r_first_cycle <= r_cyc;
                    r_first_Q_a   <= Q_a;
                    r_first_Q_b   <= Q_b;
                end
            end
        end
    end

    assign state          = r_state;
    assign mismatch       = r_mismatch;
    assign error          = r_error;
    assign mismatch_count = r_mismatch_count;
    assign first_cycle    = r_first_cycle;
    assign first_Q_a      = r_first_Q_a;
    assign first_Q_b      = r_first_Q_b;

endmodule
